// File: rtl/mel_log_pkg.sv
// ============================================================================
//  Module   : mel_log_pkg
//  Purpose  : Shared constants, types and helpers for the mel log-compression
//             stage: Q-format fraction widths, the zero-input output code,
//             the 32-entry log2 fraction table and counter width helpers.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mel_log_pkg;

   localparam int IN_FRAC  = 15;   // input is unsigned Q1.15
   localparam int OUT_FRAC = 10;   // output is signed Q5.10

   localparam logic signed [15:0] LOG_FLOOR_DEF = 16'shC000;

   // Stage-2 payload: leading-one position, mantissa index, zero flag.
   typedef struct packed {
      logic       zero;
      logic [3:0] pos;
      logic [4:0] idx;
   } s2_payload_t;

   // Width of a counter that must hold 0..n-1 (at least one bit).
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // round(1024 * log2(1 + k/32)) for k = 0..31.
   function automatic logic [OUT_FRAC-1:0] log2_frac(input logic [4:0] k);
      logic [OUT_FRAC-1:0] v;
      case (k)
         5'd0 : v = 10'd0;    5'd1 : v = 10'd45;   5'd2 : v = 10'd90;
         5'd3 : v = 10'd132;  5'd4 : v = 10'd174;  5'd5 : v = 10'd214;
         5'd6 : v = 10'd254;  5'd7 : v = 10'd292;  5'd8 : v = 10'd330;
         5'd9 : v = 10'd366;  5'd10: v = 10'd402;  5'd11: v = 10'd436;
         5'd12: v = 10'd470;  5'd13: v = 10'd504;  5'd14: v = 10'd536;
         5'd15: v = 10'd568;  5'd16: v = 10'd599;  5'd17: v = 10'd629;
         5'd18: v = 10'd659;  5'd19: v = 10'd689;  5'd20: v = 10'd717;
         5'd21: v = 10'd745;  5'd22: v = 10'd773;  5'd23: v = 10'd800;
         5'd24: v = 10'd827;  5'd25: v = 10'd853;  5'd26: v = 10'd879;
         5'd27: v = 10'd904;  5'd28: v = 10'd929;  5'd29: v = 10'd953;
         5'd30: v = 10'd977;  5'd31: v = 10'd1001;
         default: v = 10'd0;
      endcase
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mel_log_compress_lzc16.sv
// ============================================================================
//  Module   : lzc16
//  Purpose  : Combinational leading-one detector for a 16-bit word.
//  Ports    : data [15:0] in  - word to scan
//             pos  [3:0]  out - index of the most significant set bit
//                               (0 when data is zero)
//             zero        out - data is all zeros
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lzc16 (
   input  logic [15:0] data,
   output logic [3:0]  pos,
   output logic        zero
);

   // Ascending scan: the last set bit seen is the most significant one.
   always_comb begin
      pos  = 4'd0;
      zero = (data == 16'd0);
      for (int i = 0; i < 16; i++) begin
         if (data[i]) pos = 4'(i);
      end
   end

endmodule

`default_nettype wire

// File: rtl/mel_log_compress.sv
// ============================================================================
//  Module   : mel_log_compress
//  Purpose  : Converts unsigned Q1.15 mel band energies into signed Q5.10
//             log2 values through a fixed 3-stage pipeline, tracking band
//             and frame position and flagging end of frame / utterance.
//  Ports    : clk, rst          clock, asynchronous active-high reset
//             start             pulse: clear counters, arm a new utterance
//             mel_avail/mel_data input sample stream (no backpressure)
//             log_vld/log_data  output sample stream, 3 cycles after input
//             band_idx          band of the current output sample
//             frame_last        output is the last band of its frame
//             utt_done          pulse after the final output of the utterance
//             busy              high from start until utt_done
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mel_log_compress
   import mel_log_pkg::*;
#(
   parameter int                WIDTH     = 16,
   parameter int                MEL_BANDS = 40,
   parameter int                N_FRAMES  = 101,
   parameter int                LUT_BITS  = 5,
   parameter logic signed [15:0] LOG_FLOOR = LOG_FLOOR_DEF
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         mel_avail,
   input  logic [WIDTH-1:0]             mel_data,
   output logic                         log_vld,
   output logic [WIDTH-1:0]             log_data,
   output logic [$clog2(MEL_BANDS)-1:0] band_idx,
   output logic                         frame_last,
   output logic                         utt_done,
   output logic                         busy
);

   localparam int BAND_W  = $clog2(MEL_BANDS);
   localparam int FRAME_W = cnt_w(N_FRAMES);
   localparam int EXP_W   = WIDTH - OUT_FRAC;

   // ---------------------------------------------------------------- control
   logic               armed;
   logic [BAND_W-1:0]  band_cnt;
   logic [FRAME_W-1:0] frame_cnt;
   logic               accept;
   logic               band_wrap;
   logic               utt_end;

   // start wins over a coincident sample, which is dropped.
   assign accept    = mel_avail & armed & ~start;
   assign band_wrap = (band_cnt == BAND_W'(MEL_BANDS - 1));
   assign utt_end   = band_wrap & (frame_cnt == FRAME_W'(N_FRAMES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed     <= 1'b0;
         band_cnt  <= '0;
         frame_cnt <= '0;
      end else if (start) begin
         armed     <= 1'b1;
         band_cnt  <= '0;
         frame_cnt <= '0;
      end else if (accept) begin
         if (band_wrap) begin
            band_cnt <= '0;
            if (utt_end) begin
               armed     <= 1'b0;
               frame_cnt <= '0;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end else begin
            band_cnt <= band_cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- stage 1
   logic              s1_vld;
   logic [15:0]       s1_x;
   logic [BAND_W-1:0] s1_band;
   logic              s1_frame_last;
   logic              s1_utt_end;
   logic [3:0]        s1_pos;
   logic              s1_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld        <= 1'b0;
         s1_x          <= '0;
         s1_band       <= '0;
         s1_frame_last <= 1'b0;
         s1_utt_end    <= 1'b0;
      end else begin
         s1_vld        <= accept;
         s1_x          <= mel_data;
         s1_band       <= band_cnt;
         s1_frame_last <= band_wrap;
         s1_utt_end    <= utt_end;
      end
   end

   lzc16 u_lzc (
      .data (s1_x),
      .pos  (s1_pos),
      .zero (s1_zero)
   );

   // ---------------------------------------------------------------- stage 2
   s2_payload_t       s2_next;
   s2_payload_t       s2;
   logic              s2_vld;
   logic [BAND_W-1:0] s2_band;
   logic              s2_frame_last;
   logic              s2_utt_end;

   // Normalise so the leading one sits at bit 15; the next LUT_BITS bits
   // below it are the mantissa index.
   always_comb begin
      s2_next.zero = s1_zero;
      s2_next.pos  = s1_pos;
      s2_next.idx  = LUT_BITS'((s1_x << (4'd15 - s1_pos)) >> (IN_FRAC - LUT_BITS));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_vld        <= 1'b0;
         s2            <= '0;
         s2_band       <= '0;
         s2_frame_last <= 1'b0;
         s2_utt_end    <= 1'b0;
      end else begin
         s2_vld        <= s1_vld & ~start;
         s2            <= s2_next;
         s2_band       <= s1_band;
         s2_frame_last <= s1_frame_last;
         s2_utt_end    <= s1_utt_end;
      end
   end

   // ---------------------------------------------------------------- stage 3
   logic [EXP_W-1:0] exp_int;
   logic             s3_utt_end;

   // Integer part p-15 is in -15..0 and the LUT fraction is below 1.0, so
   // the Q5.10 sum is just the signed integer concatenated with the fraction.
   assign exp_int = EXP_W'(s2.pos) - EXP_W'(IN_FRAC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         log_vld    <= 1'b0;
         log_data   <= '0;
         band_idx   <= '0;
         frame_last <= 1'b0;
         s3_utt_end <= 1'b0;
         utt_done   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         log_vld    <= s2_vld & ~start;
         log_data   <= s2.zero ? WIDTH'(LOG_FLOOR) : {exp_int, log2_frac(s2.idx)};
         band_idx   <= s2_band;
         frame_last <= s2_vld & s2_frame_last & ~start;
         s3_utt_end <= s2_utt_end;
         // An abort via start suppresses the pending end-of-utterance.
         utt_done   <= log_vld & s3_utt_end & ~start;
         if (start)
            busy <= 1'b1;
         else if (log_vld & s3_utt_end)
            busy <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mel_log_compress.sv
`timescale 1ns/1ps
`default_nettype none

module tb_mel_log_compress;

   localparam int MEL_BANDS = 40;
   localparam int N_FRAMES  = 101;
   localparam int BW        = $clog2(MEL_BANDS);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          mel_avail;
   logic [15:0]   mel_data;
   logic          log_vld;
   logic [15:0]   log_data;
   logic [BW-1:0] band_idx;
   logic          frame_last;
   logic          utt_done;
   logic          busy;

   mel_log_compress #(
      .WIDTH     (16),
      .MEL_BANDS (MEL_BANDS),
      .N_FRAMES  (N_FRAMES),
      .LUT_BITS  (5),
      .LOG_FLOOR (16'shC000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mel_avail  (mel_avail),
      .mel_data   (mel_data),
      .log_vld    (log_vld),
      .log_data   (log_data),
      .band_idx   (band_idx),
      .frame_last (frame_last),
      .utt_done   (utt_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0]   data;
      logic [BW-1:0] band;
      logic          fl;
      logic          last;
      int            stamp;
   } exp_t;

   typedef struct {
      logic [15:0] din;
      logic [15:0] dout;
   } vec_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Reference model state
   logic m_armed = 1'b0;
   int   m_band = 0;
   int   m_frame = 0;
   int   busy_on_at = -1;
   int   done_at = -1;
   logic exp_busy = 1'b0;
   logic exp_done;
   int   done_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Independent log2 reference built from real arithmetic.
   function automatic logic [15:0] ref_log(input logic [15:0] x);
      int  p;
      int  k;
      int  lut;
      int  v;
      real frac;
      if (x == 16'd0) return 16'hC000;
      p = 0;
      for (int i = 0; i < 16; i++) if (x[i]) p = i;
      frac = real'(x) / (2.0 ** p) - 1.0;
      k    = int'($floor(frac * 32.0));
      lut  = int'(1024.0 * $ln(1.0 + real'(k) / 32.0) / $ln(2.0));
      v    = (p - 15) * 1024 + lut;
      return 16'(v);
   endfunction

   // One cycle of stimulus; pushes the expected output when the model accepts.
   task automatic drive(input logic av, input logic [15:0] d, input logic st,
                        input logic [15:0] exp_d);
      exp_t e;
      @(posedge clk); #1;
      mel_avail = av;
      mel_data  = d;
      start     = st;
      if (st) begin
         for (int i = q.size() - 1; i >= 0; i--) if (q[i].stamp > cyc) q.delete(i);
         m_armed    = 1'b1;
         m_band     = 0;
         m_frame    = 0;
         busy_on_at = cyc + 1;
      end else if (av && m_armed) begin
         e.data  = exp_d;
         e.band  = BW'(m_band);
         e.fl    = (m_band == MEL_BANDS - 1);
         e.last  = e.fl && (m_frame == N_FRAMES - 1);
         e.stamp = cyc + 3;
         q.push_back(e);
         if (e.last) m_armed = 1'b0;
         if (e.fl) begin
            m_band  = 0;
            m_frame = m_frame + 1;
         end else begin
            m_band = m_band + 1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 16'd0, 1'b0, 16'd0);
   endtask

   task automatic send_rand();
      logic [15:0] d;
      if ($urandom_range(0, 3) == 0) d = 16'(32'd1 << $urandom_range(0, 15));
      else if ($urandom_range(0, 15) == 0) d = 16'd0;
      else d = 16'($urandom);
      drive(1'b1, d, 1'b0, ref_log(d));
   endtask

   // Output monitor / scoreboard
   always @(negedge clk) begin
      if (cyc == busy_on_at) exp_busy = 1'b1;
      checks++;
      if (log_vld) begin
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output cyc=%0d got data=%h band=%0d, none expected",
                     cyc, log_data, band_idx);
         end else begin
            mon_e = q.pop_front();
            if (mon_e.stamp != cyc || log_data !== mon_e.data ||
                band_idx !== mon_e.band || frame_last !== mon_e.fl) begin
               errors++;
               $display("FAIL output cyc=%0d got data=%h band=%0d fl=%b, want cyc=%0d data=%h band=%0d fl=%b",
                        cyc, log_data, band_idx, frame_last, mon_e.stamp, mon_e.data,
                        mon_e.band, mon_e.fl);
            end
            if (mon_e.last) done_at = cyc + 1;
         end
      end else begin
         if (q.size() > 0 && q[0].stamp <= cyc) begin
            errors++;
            $display("FAIL missing_output cyc=%0d got no log_vld, want data=%h band=%0d",
                     cyc, q[0].data, q[0].band);
            void'(q.pop_front());
         end else if (frame_last !== 1'b0) begin
            errors++;
            $display("FAIL idle_frame_last cyc=%0d got %b want 0", cyc, frame_last);
         end
      end
      exp_done = (cyc == done_at);
      if (exp_done) begin
         exp_busy = 1'b0;
         done_seen++;
      end
      checks++;
      if (utt_done !== exp_done) begin
         errors++;
         $display("FAIL utt_done cyc=%0d got %b want %b", cyc, utt_done, exp_done);
      end
      checks++;
      if (busy !== exp_busy) begin
         errors++;
         $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, exp_busy);
      end
   end

   task automatic check_bit(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %b want %b", name, got, want);
      end
   endtask

   initial begin
      vec_t tbl[6];
      int   seen_before;

      tbl[0] = '{16'h8000, 16'h0000};
      tbl[1] = '{16'h4000, 16'hFC00};
      tbl[2] = '{16'h6000, 16'hFE57};
      tbl[3] = '{16'h0001, 16'hC400};
      tbl[4] = '{16'h0000, 16'hC000};
      tbl[5] = '{16'hFFFF, 16'h03E9};

      rst = 1'b1; start = 1'b0; mel_avail = 1'b0; mel_data = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      check_bit("reset_log_vld", log_vld, 1'b0);
      check_bit("reset_frame_last", frame_last, 1'b0);
      check_bit("reset_utt_done", utt_done, 1'b0);
      check_bit("reset_busy", busy, 1'b0);
      checks++;
      if (log_data !== 16'd0 || band_idx !== '0) begin
         errors++;
         $display("FAIL reset_data got data=%h band=%0d want 0 0", log_data, band_idx);
      end
      rst = 1'b0;

      // No start: input must be ignored.
      for (int i = 0; i < 8; i++) drive(1'(i % 2), 16'h1234 + 16'(i), 1'b0, 16'd0);
      idle(4);

      // Basic values, back to back.
      drive(1'b0, 16'd0, 1'b1, 16'd0);
      for (int i = 0; i < 6; i++) drive(1'b1, tbl[i].din, 1'b0, tbl[i].dout);
      idle(6);

      // Full utterance; random gaps inside the first frame, then 5 extras.
      drive(1'b0, 16'd0, 1'b1, 16'd0);
      for (int s = 0; s < MEL_BANDS * N_FRAMES; s++) begin
         if (s < MEL_BANDS && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         send_rand();
      end
      for (int i = 0; i < 5; i++) send_rand();
      idle(8);
      checks++;
      if (done_seen != 1) begin
         errors++;
         $display("FAIL utt_done_count got %0d want 1", done_seen);
      end

      // Abort at band 17 with a coincident sample.
      seen_before = done_seen;
      drive(1'b0, 16'd0, 1'b1, 16'd0);
      for (int i = 0; i < 17; i++) send_rand();
      drive(1'b1, 16'h7777, 1'b1, 16'd0);
      for (int i = 0; i < 3; i++) send_rand();
      idle(8);
      checks++;
      if (done_seen != seen_before) begin
         errors++;
         $display("FAIL abort_utt_done got %0d pulses want 0", done_seen - seen_before);
      end

      // Asynchronous reset with samples in flight.
      drive(1'b0, 16'd0, 1'b1, 16'd0);
      for (int i = 0; i < 3; i++) send_rand();
      @(posedge clk); #1;
      mel_avail = 1'b0; start = 1'b0;
      #1;
      check_bit("pre_reset_log_vld", log_vld, 1'b1);
      check_bit("pre_reset_busy", busy, 1'b1);
      rst = 1'b1;
      q.delete();
      m_armed = 1'b0; exp_busy = 1'b0; busy_on_at = -1; done_at = -1;
      #1;
      check_bit("async_reset_log_vld", log_vld, 1'b0);
      check_bit("async_reset_frame_last", frame_last, 1'b0);
      check_bit("async_reset_utt_done", utt_done, 1'b0);
      check_bit("async_reset_busy", busy, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) send_rand();
      idle(6);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mel_log_compress.md
Name: mel_log_compress

Overview:
Downstream stage of the mel spectrogram block: converts each unsigned Q1.15 mel band energy (mel_data/mel_avail stream) to a signed Q5.10 log2 value for the classifier front end.
- Fixed 3-cycle pipeline, no backpressure.
- Tracks band and frame position; flags end-of-frame and end-of-utterance.
- Stalls (drops input) once N_FRAMES frames are done, until the next start.

Parameters:
WIDTH, 16, input and output sample width (the design supports only 16)
MEL_BANDS, 40, mel values per frame
N_FRAMES, 101, frames per utterance
LUT_BITS, 5, mantissa bits indexing the fraction LUT (32 entries)
LOG_FLOOR, -16384 (0xC000), output code for a zero input

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: clear counters, arm for a new utterance
mel_avail  in  1  input sample valid
mel_data  in  WIDTH  unsigned Q1.15 mel energy
log_vld  out  1  output sample valid
log_data  out  WIDTH  signed Q5.10 log2(mel_data/2^15)
band_idx  out  $clog2(MEL_BANDS)  band index of the current output
frame_last  out  1  high with the output for band MEL_BANDS-1
utt_done  out  1  one-cycle pulse after the final output of frame N_FRAMES-1
busy  out  1  high from start until utt_done

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; pipeline valids 0; band and frame counters 0; armed=0.
- Input acceptance: a sample is accepted when mel_avail=1 and armed=1; otherwise it is silently dropped.
- start: sets armed=1, clears the band and frame counters, flushes pipeline valids.
  - Start takes priority over a mel_avail in the same cycle; that sample is dropped.
  - Start while busy aborts the in-flight utterance. No utt_done is issued for it.
- Pipeline, 3 cycles: log_vld is asserted exactly 3 cycles after an accepted mel_avail. Fully pipelined, 1 sample per cycle sustained.
  - S1: register x; compute zero flag; leading-one position p (0..15) via the lzc sub-module.
  - S2: mantissa m = (x << (15-p)) [14:15-LUT_BITS] gives index k; register p, k, zero flag.
  - S3: log_data = ((p-15) <<< 10) + LUT[k], or LOG_FLOOR if zero. Register it, along with band_idx and frame_last.
- LUT: LUT[k] = round(1024*log2(1+k/32)), k=0..31, unsigned 10-bit. For example LUT[0]=0, LUT[8]=330, LUT[16]=599, LUT[31]=1001.
- Output range: -15360..+1001; LOG_FLOOR is reserved for zero input. No saturation is needed.
- Band counter: increments per accepted sample and wraps at MEL_BANDS-1 to 0.
  - On the wrap, the frame counter increments.
  - band_idx and frame_last travel through the pipeline aligned with their sample.
- Frame counter:
  - At acceptance of the sample with band=MEL_BANDS-1 and frame=N_FRAMES-1, armed clears, so later inputs are dropped.
  - utt_done pulses 1 cycle after that sample's log_vld.
  - busy clears in the same cycle utt_done pulses.
- mel_avail gaps are allowed anywhere; counters only advance on accepted samples.
- Reset mid-utterance: everything returns to the reset state immediately; in-flight samples are lost.

Decomposition:
- Package mel_log_pkg:
  - Q-format constants (IN_FRAC=15, OUT_FRAC=10).
  - LOG_FLOOR default.
  - The 32-entry LUT as a localparam array or constant function.
  - Width helpers for the band and frame counters.
- Sub-module lzc16: combinational leading-one detector, 16-bit input → 4-bit position plus zero flag. Reusable by later dB/normalisation stages.

Test Plan:
- Basic values: after start, feed mel_data 0x8000, 0x4000, 0x6000, 0x0001, 0x0000, 0xFFFF on consecutive cycles → log_data 0x0000, 0xFC00, 0xFE57, 0xC400, 0xC000, 0x03E9, each exactly 3 cycles after its input, back to back.
- Framing: one full frame of 40 samples with random gaps → band_idx 0..39 aligned with log_vld; frame_last only with band 39.
- Utterance end: 101×40 samples, then 5 extra samples → utt_done pulses once, 1 cycle after the 4040th log_vld; busy drops with it; the extras produce no log_vld.
- No start: mel_avail toggling after reset without start → log_vld stays 0.
- Abort: start re-issued mid-frame at band 17, same cycle as mel_avail → that sample is dropped; the next output has band_idx 0; no utt_done for the aborted run.
- Reset: rst asserted with 2 samples in the pipeline → log_vld, frame_last, utt_done and busy go 0 asynchronously; nothing is output after rst deasserts until start.
